// File: rtl/seq_wide_adder.sv
// rtl/seq_wide_adder.sv - multi-cycle wide adder over one shared prefix slice; OVF enabled by SEQ_WIDE_ADDER_OVF_EN

package lau_pkg;
   typedef enum logic {SLOW = 1'b0, FAST = 1'b1} speed_t;
endpackage

// Prefix AND-OR carry network with the carry-in folded into bit 0.
// go[i] is the carry out of bit i for the whole span [0..i].
module seq_wide_adder_slice #(
   parameter int              width = 8,
   parameter lau_pkg::speed_t speed = lau_pkg::FAST
) (
   input  logic [width-1:0] gi,
   input  logic [width-1:0] pi,
   input  logic             ci,
   output logic [width-1:0] go
);
   if (speed == lau_pkg::FAST) begin : g_fast
      localparam int LV = $clog2(width);
      logic [width-1:0] g_lv [LV+1];
      logic [width-1:0] p_lv [LV+1];

      // Kogge-Stone style log-depth prefix tree
      always_comb begin
         g_lv[0]    = gi;
         g_lv[0][0] = gi[0] | (pi[0] & ci);
         p_lv[0]    = pi;
         for (int l = 1; l <= LV; l++) begin
            g_lv[l] = g_lv[l-1];
            p_lv[l] = p_lv[l-1];
            for (int i = (1 << (l-1)); i < width; i++) begin
               g_lv[l][i] = g_lv[l-1][i] | (p_lv[l-1][i] & g_lv[l-1][i-(1 << (l-1))]);
               p_lv[l][i] = p_lv[l-1][i] & p_lv[l-1][i-(1 << (l-1))];
            end
         end
      end

      assign go = g_lv[LV];
   end else begin : g_slow
      logic c;

      // linear ripple prefix, smallest network
      always_comb begin
         go = '0;
         c  = ci;
         for (int i = 0; i < width; i++) begin
            c     = gi[i] | (pi[i] & c);
            go[i] = c;
         end
      end
   end
endmodule

module seq_wide_adder #(
   parameter int              width  = 8,
   parameter int              chunks = 4,
   parameter lau_pkg::speed_t speed  = lau_pkg::FAST
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [width*chunks-1:0] A,
   input  logic [width*chunks-1:0] B,
   input  logic                    CI,
   input  logic                    VI,
   output logic                    RI,
   output logic [width*chunks-1:0] S,
   output logic                    CO,
   output logic                    OVF,
   output logic                    VO,
   input  logic                    RO
);
   localparam int N  = width * chunks;
   localparam int CW = (chunks > 1) ? $clog2(chunks) : 1;
   localparam logic [CW-1:0] LAST = CW'(chunks - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [N-1:0]     a_q, a_d;
   logic [N-1:0]     b_q, b_d;
   logic [N-1:0]     s_q, s_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [width-1:0] a_k, b_k, go, sum_k;

   // select the operand chunk addressed by the counter
   always_comb begin
      a_k = '0;
      b_k = '0;
      for (int k = 0; k < chunks; k++) begin
         if (cnt_q == CW'(k)) begin
            a_k = a_q[k*width +: width];
            b_k = b_q[k*width +: width];
         end
      end
   end

   seq_wide_adder_slice #(
      .width (width),
      .speed (speed)
   ) u_slice (
      .gi (a_k & b_k),
      .pi (a_k ^ b_k),
      .ci (carry_q),
      .go (go)
   );

   assign sum_k = (a_k ^ b_k) ^ {go[width-2:0], carry_q};

   // control FSM plus operand, sum and carry register updates
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (VI) begin
               a_d     = A;
               b_d     = B;
               carry_d = CI;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int k = 0; k < chunks; k++) begin
               if (cnt_q == CW'(k)) begin
                  s_d[k*width +: width] = sum_k;
               end
            end
            carry_d = go[width-1];
            // counter parks on the last chunk instead of wrapping
            if (cnt_q == LAST) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (RO) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef SEQ_WIDE_ADDER_OVF_EN
   logic ovf_q, ovf_d;

   // capture carry-into-MSB xor carry-out on the top chunk
   always_comb begin
      ovf_d = ovf_q;
      if ((state_q == RUN) && (cnt_q == LAST)) begin
         ovf_d = go[width-2] ^ go[width-1];
      end
   end

   // overflow flag register
   always_ff @(posedge CLK) begin
      if (RST) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign OVF = ovf_q;
`else
   assign OVF = 1'b0;
`endif

   assign RI = (state_q == IDLE);
   assign VO = (state_q == DONE);
   assign S  = s_q;
   assign CO = carry_q;
endmodule
